// File: rtl/gf_loader_pkg.sv
// Shared definitions for the pattern-RAM loader: geometry, command-word
// bit positions and the transfer state machine encoding.
package gf_loader_pkg;

    localparam int WIDTH      = 756;
    localparam int DEPTH_LOG2 = 10;

    localparam int CMD_GO      = 31;
    localparam int CMD_USE_PTR = 30;
    localparam int CMD_CLR     = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/gf_write_edge_detect.sv
// Turns a level VME write strobe into one pulse per strobe; the veto holds
// until the strobe itself drops, so address glitches cannot re-fire it.
module gf_write_edge_detect (
    input  logic clk,
    input  logic init_n,
    input  logic sel,
    input  logic strobe,
    output logic pulse
);

    logic sel_reg;
    logic veto_reg;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sel_reg  <= 1'b0;
            veto_reg <= 1'b0;
        end else begin
            sel_reg  <= sel;
            // Strobe low always re-arms, even in the pulse cycle itself.
            veto_reg <= strobe & (veto_reg | pulse);
        end
    end

    assign pulse = sel_reg & ~veto_reg;

endmodule

// File: rtl/gf_ram_loader756.sv
// Command-driven loader: copies the wide VME register into an external
// pattern RAM at a direct or auto-incremented address, fixed 3-cycle latency.
module gf_ram_loader756 #(
    parameter int WIDTH      = gf_loader_pkg::WIDTH,
    parameter int DEPTH_LOG2 = gf_loader_pkg::DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  init_n,
    input  logic [15:0]           address,
    input  logic [15:0]           DECODE_ADDRESS,
    input  logic                  writeRegister,
    input  logic [31:0]           data,
    output logic                  ram_writePulse,
    input  logic [WIDTH-1:0]      ram_data_bus,
    output logic                  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_din,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] ptr,
    output logic                  overrun,
    output logic                  wrapped
);
    import gf_loader_pkg::*;

    logic                  cmd_sel;
    logic                  cmd_pulse;
    logic                  cmd_go;
    logic                  cmd_clr;
    logic                  cmd_use_ptr;
    logic [DEPTH_LOG2-1:0] cmd_addr;
    logic                  unused_data;

    state_t                state_reg;
    logic [DEPTH_LOG2-1:0] target_reg;
    logic                  inc_reg;
    logic [WIDTH-1:0]      holding_reg;
    logic                  in_flight;

    assign cmd_sel = (address == DECODE_ADDRESS) && writeRegister;

    gf_write_edge_detect u_edge (
        .clk    (clk),
        .init_n (init_n),
        .sel    (cmd_sel),
        .strobe (writeRegister),
        .pulse  (cmd_pulse)
    );

    assign cmd_go      = cmd_pulse & data[CMD_GO];
    assign cmd_clr     = cmd_pulse & data[CMD_CLR];
    assign cmd_use_ptr = data[CMD_USE_PTR];
    assign cmd_addr    = data[DEPTH_LOG2-1:0];
    assign unused_data = ^data[CMD_CLR-1:DEPTH_LOG2];

    assign in_flight = (state_reg != IDLE);
    assign ram_din   = holding_reg;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_reg      <= IDLE;
            target_reg     <= '0;
            inc_reg        <= 1'b0;
            holding_reg    <= '0;
            ram_writePulse <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ptr            <= '0;
            overrun        <= 1'b0;
            wrapped        <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cmd_go) begin
                        state_reg      <= DRIVE;
                        busy           <= 1'b1;
                        ram_writePulse <= 1'b1;
                        inc_reg        <= cmd_use_ptr;
                        // A simultaneous clear takes effect before the target is chosen.
                        if (cmd_use_ptr)
                            target_reg <= cmd_clr ? '0 : ptr;
                        else
                            target_reg <= cmd_addr;
                    end
                end
                DRIVE: begin
                    state_reg <= LATCH;
                end
                LATCH: begin
                    state_reg      <= WRITE;
                    holding_reg    <= ram_data_bus;
                    ram_writePulse <= 1'b0;
                    ram_we         <= 1'b1;
                    done           <= 1'b1;
                    ram_addr       <= target_reg;
                end
                WRITE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (cmd_clr) begin
                ptr     <= '0;
                overrun <= 1'b0;
                wrapped <= 1'b0;
                if (in_flight)
                    inc_reg <= 1'b0;
            end else if (state_reg == WRITE && inc_reg) begin
                ptr <= ptr + 1'b1;
                if (&ptr)
                    wrapped <= 1'b1;
            end

            if (cmd_go && in_flight)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gf_ram_loader756.sv
// Randomised bench for gf_ram_loader756 with a queue-based reference model
// of the command semantics and an observed-write log.
module tb_gf_ram_loader756;

    localparam int W     = 756;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam logic [15:0] DEC = 16'h1A20;

    logic          clk = 1'b0;
    logic          init_n = 1'b0;
    logic [15:0]   address = '0;
    logic [15:0]   decode_address = DEC;
    logic          writeRegister = 1'b0;
    logic [31:0]   data = '0;
    logic          ram_writePulse;
    logic [W-1:0]  ram_data_bus;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_din;
    logic          busy;
    logic          done;
    logic [AW-1:0] ptr;
    logic          overrun;
    logic          wrapped;

    logic [W-1:0]  pattern = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Observed activity
    int           wr_addr_q[$];
    logic [W-1:0] wr_din_q[$];
    int           wr_cyc_q[$];
    int           wp_cyc_q[$];
    int           done_cyc_q[$];
    int           busy_cyc_q[$];

    // Reference model state
    int           exp_addr_q[$];
    logic [W-1:0] exp_din_q[$];
    int           m_ptr = 0;
    bit           m_wrap = 1'b0;
    bit           m_ovr = 1'b0;

    gf_ram_loader756 #(.WIDTH(W), .DEPTH_LOG2(AW)) dut (
        .clk            (clk),
        .init_n         (init_n),
        .address        (address),
        .DECODE_ADDRESS (decode_address),
        .writeRegister  (writeRegister),
        .data           (data),
        .ram_writePulse (ram_writePulse),
        .ram_data_bus   (ram_data_bus),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .busy           (busy),
        .done           (done),
        .ptr            (ptr),
        .overrun        (overrun),
        .wrapped        (wrapped)
    );

    // The wide register only drives the bus while enabled.
    assign ram_data_bus = ram_writePulse ? pattern : '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_din_q.push_back(ram_din);
            wr_cyc_q.push_back(cyc);
        end
        if (ram_writePulse) wp_cyc_q.push_back(cyc);
        if (done)           done_cyc_q.push_back(cyc);
        if (busy)           busy_cyc_q.push_back(cyc);
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < 24; i++) w = {w[W-33:0], 32'($urandom)};
        return w;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_din_q.delete(); wr_cyc_q.delete();
        wp_cyc_q.delete(); done_cyc_q.delete(); busy_cyc_q.delete();
        exp_addr_q.delete(); exp_din_q.delete();
    endtask

    // Command semantics for a command issued while the block is idle.
    task automatic model_cmd(input logic [31:0] d);
        if (d[29]) begin m_ptr = 0; m_ovr = 1'b0; m_wrap = 1'b0; end
        if (d[31]) begin
            exp_addr_q.push_back(d[30] ? m_ptr : int'(d[9:0]));
            exp_din_q.push_back(pattern);
            if (d[30]) begin
                if (m_ptr == DEPTH - 1) m_wrap = 1'b1;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [15:0] a, input int hold, output int n);
        pattern = rand_word();
        @(negedge clk);
        address = a; data = d; writeRegister = 1'b1;
        @(negedge clk);
        n = cyc;
        repeat (hold - 1) @(negedge clk);
        writeRegister = 1'b0;
    endtask

    // Second strobe lands 'gap' cycles after the first command pulse.
    task automatic two_cmds(input logic [31:0] d1, input logic [31:0] d2, input int gap, output int n);
        pattern = rand_word();
        @(negedge clk);
        address = DEC; data = d1; writeRegister = 1'b1;
        @(negedge clk);
        n = cyc;
        writeRegister = 1'b0;
        repeat (gap - 1) @(negedge clk);
        data = d2; writeRegister = 1'b1;
        @(negedge clk);
        writeRegister = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%b required 0", busy); end
    endtask

    task automatic test_reset();
        init_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ram_writePulse !== 1'b0) begin errors++; $display("FAIL reset_wp got=%b exp=0", ram_writePulse); end
        checks++; if (ram_we !== 1'b0)   begin errors++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ptr !== '0)        begin errors++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (wrapped !== 1'b0)  begin errors++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
        checks++; if (ram_addr !== '0)   begin errors++; $display("FAIL reset_addr got=%0d exp=0", ram_addr); end
        checks++; if (ram_din !== '0)    begin errors++; $display("FAIL reset_din got=%h exp=0", ram_din[63:0]); end
        init_n = 1'b1;
        m_ptr = 0; m_wrap = 1'b0; m_ovr = 1'b0;
        $display("reset: outputs checked at reset values");
    endtask

    task automatic test_direct();
        int n;
        clear_logs();
        send(32'h8000_0005, DEC, 1, n);
        model_cmd(32'h8000_0005);
        wait_idle();
        repeat (2) @(negedge clk);
        checks++; if (wp_cyc_q.size() != 2 || wp_cyc_q[0] != n + 1 || wp_cyc_q[1] != n + 2) begin
            errors++; $display("FAIL direct_wp count=%0d first=%0d required 2 cycles from %0d", wp_cyc_q.size(), wp_cyc_q.size() ? wp_cyc_q[0] : -1, n + 1); end
        checks++; if (busy_cyc_q.size() != 3 || busy_cyc_q[0] != n + 1) begin
            errors++; $display("FAIL direct_busy count=%0d required 3 from %0d", busy_cyc_q.size(), n + 1); end
        checks++; if (wr_cyc_q.size() != 1 || wr_cyc_q[0] != n + 3) begin
            errors++; $display("FAIL direct_we count=%0d cyc=%0d required 1 at %0d", wr_cyc_q.size(), wr_cyc_q.size() ? wr_cyc_q[0] : -1, n + 3); end
        checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != n + 3) begin
            errors++; $display("FAIL direct_done count=%0d required 1 at %0d", done_cyc_q.size(), n + 3); end
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != exp_addr_q[0] || wr_din_q[0] !== exp_din_q[0]) begin
            errors++; $display("FAIL direct_write addr=%0d required %0d", wr_addr_q.size() ? wr_addr_q[0] : -1, exp_addr_q[0]); end
        checks++; if (ptr !== '0) begin errors++; $display("FAIL direct_ptr got=%0d exp=0", ptr); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== 10'd5 || ram_din !== exp_din_q[0]) begin
            errors++; $display("FAIL direct_hold we=%b addr=%0d required we=0 addr=5 with din kept", ram_we, ram_addr); end
        $display("direct: cmd 80000005 pulse@%0d write@%0d addr=%0d", n, wr_cyc_q.size() ? wr_cyc_q[0] : -1, ram_addr);
    endtask

    task automatic test_ptr_mode();
        int n;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            send(32'hC000_0000, DEC, 1, n);
            model_cmd(32'hC000_0000);
            wait_idle();
        end
        checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL ptr_count got=%0d exp=3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] != exp_addr_q[i] || wr_din_q[i] !== exp_din_q[i]) begin
                errors++; $display("FAIL ptr_write%0d addr=%0d din=%h required addr=%0d din=%h", i, wr_addr_q[i], wr_din_q[i][63:0], exp_addr_q[i], exp_din_q[i][63:0]);
            end
        end
        checks++; if (ptr !== 10'd3) begin errors++; $display("FAIL ptr_final got=%0d exp=3", ptr); end
        $display("ptr_mode: 3 writes, ptr=%0d", ptr);
    endtask

    task automatic test_random_mix();
        int n;
        logic [31:0] d;
        logic [15:0] a;
        logic [9:0]  low;
        logic [2:0]  kind;
        clear_logs();
        send(32'h2000_0000, DEC, 1, n);
        model_cmd(32'h2000_0000);
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            low  = 10'($urandom);
            kind = 3'($urandom_range(0, 4));
            case (kind)
                3'd0:    d = 32'h8000_0000 | 32'(low);
                3'd1:    d = 32'hC000_0000 | 32'(low);
                3'd2:    d = 32'h2000_0000 | 32'(low);
                3'd3:    d = ($urandom_range(0, 1) ? 32'h4000_0000 : 32'h0) | 32'(low);
                default: d = 32'hA000_0000 | ($urandom_range(0, 1) ? 32'h4000_0000 : 32'h0) | 32'(low);
            endcase
            a = ($urandom_range(0, 7) == 0) ? (DEC ^ 16'h0004) : DEC;
            send(d, a, $urandom_range(1, 4), n);
            if (a == DEC) model_cmd(d);
            wait_idle();
            $display("mix[%0d]: addr=%h data=%h ptr=%0d", i, a, d, ptr);
        end
        address = DEC;
        checks++; if (wr_addr_q.size() != exp_addr_q.size()) begin
            errors++; $display("FAIL mix_count got=%0d exp=%0d", wr_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] != exp_addr_q[i] || wr_din_q[i] !== exp_din_q[i]) begin
                errors++; $display("FAIL mix_write%0d addr=%0d din=%h required addr=%0d din=%h", i, wr_addr_q[i], wr_din_q[i][63:0], exp_addr_q[i], exp_din_q[i][63:0]);
            end
        end
        checks++; if (ptr !== AW'(m_ptr) || wrapped !== m_wrap || overrun !== m_ovr) begin
            errors++; $display("FAIL mix_state ptr=%0d wr=%b ov=%b required ptr=%0d wr=%b ov=%b", ptr, wrapped, overrun, m_ptr, m_wrap, m_ovr); end
    endtask

    task automatic test_overrun();
        int n;
        clear_logs();
        two_cmds(32'h8000_0011, 32'h8000_0022, 2, n);
        wait_idle();
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 'h11 || wr_cyc_q[0] != n + 3) begin
            errors++; $display("FAIL overrun_write count=%0d addr=%0d required 1 write to 17 at %0d", wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : -1, n + 3); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
        $display("overrun: second go dropped, writes=%0d overrun=%b", wr_addr_q.size(), overrun);

        clear_logs();
        send(32'h8000_0033, DEC, 20, n);
        wait_idle();
        repeat (3) @(negedge clk);
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 'h33) begin
            errors++; $display("FAIL long_strobe count=%0d required 1 write to 51", wr_addr_q.size()); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
        send(32'h2000_0000, DEC, 1, n);
        wait_idle();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
        $display("long_strobe: writes=%0d overrun after clear=%b", wr_addr_q.size(), overrun);
    endtask

    task automatic test_clear_busy();
        int n;
        clear_logs();
        for (int i = 0; i < 2; i++) begin send(32'hC000_0000, DEC, 1, n); wait_idle(); end
        clear_logs();
        two_cmds(32'hC000_0000, 32'h2000_0000, 2, n);
        wait_idle();
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 2) begin
            errors++; $display("FAIL clear_busy_write count=%0d addr=%0d required 1 write to 2", wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : -1); end
        checks++; if (ptr !== '0) begin errors++; $display("FAIL clear_busy_ptr got=%0d exp=0", ptr); end
        $display("clear_busy: write addr=%0d ptr=%0d", wr_addr_q.size() ? wr_addr_q[0] : -1, ptr);
    endtask

    task automatic test_clear_go();
        int n;
        send(32'h2000_0000, DEC, 1, n);
        wait_idle();
        for (int i = 0; i < 7; i++) begin send(32'hC000_0000, DEC, 1, n); wait_idle(); end
        checks++; if (ptr !== 10'd7) begin errors++; $display("FAIL clear_go_pre ptr=%0d exp=7", ptr); end
        clear_logs();
        send(32'hE000_0000, DEC, 1, n);
        wait_idle();
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0) begin
            errors++; $display("FAIL clear_go_write count=%0d addr=%0d required 1 write to 0", wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : -1); end
        checks++; if (ptr !== 10'd1) begin errors++; $display("FAIL clear_go_ptr got=%0d exp=1", ptr); end
        $display("clear_go: write addr=0 ptr=%0d", ptr);
    endtask

    task automatic test_wrap();
        int n;
        clear_logs();
        send(32'h2000_0000, DEC, 1, n);
        model_cmd(32'h2000_0000);
        wait_idle();
        for (int i = 0; i < DEPTH - 1; i++) begin
            send(32'hC000_0000, DEC, 1, n); model_cmd(32'hC000_0000); wait_idle();
        end
        // Clear lands in the WRITE cycle of the wrapping transfer.
        two_cmds(32'hC000_0000, 32'h2000_0000, 3, n);
        model_cmd(32'hC000_0000);
        model_cmd(32'h2000_0000);
        wait_idle();
        checks++; if (ptr !== '0 || wrapped !== 1'b0) begin
            errors++; $display("FAIL wrap_clear ptr=%0d wrapped=%b required 0/0", ptr, wrapped); end
        $display("wrap_clear: ptr=%0d wrapped=%b", ptr, wrapped);
        for (int i = 0; i < DEPTH; i++) begin
            send(32'hC000_0000, DEC, 1, n); model_cmd(32'hC000_0000); wait_idle();
        end
        checks++; if (wr_addr_q.size() != exp_addr_q.size()) begin
            errors++; $display("FAIL wrap_count got=%0d exp=%0d", wr_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] != exp_addr_q[i] || wr_din_q[i] !== exp_din_q[i]) begin
                errors++; $display("FAIL wrap_write%0d addr=%0d required %0d", i, wr_addr_q[i], exp_addr_q[i]);
            end
        end
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] != DEPTH - 1) begin
            errors++; $display("FAIL wrap_last addr=%0d exp=%0d", wr_addr_q.size() ? wr_addr_q[wr_addr_q.size() - 1] : -1, DEPTH - 1); end
        checks++; if (ptr !== '0 || wrapped !== 1'b1) begin
            errors++; $display("FAIL wrap_flag ptr=%0d wrapped=%b required 0/1", ptr, wrapped); end
        $display("wrap: writes=%0d ptr=%0d wrapped=%b", wr_addr_q.size(), ptr, wrapped);
        send(32'h2000_0000, DEC, 1, n);
        wait_idle();
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_cleared got=%b exp=0", wrapped); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        pattern = rand_word();
        @(negedge clk);
        address = DEC; data = 32'h8000_0009; writeRegister = 1'b1;
        @(negedge clk);
        n = cyc;
        writeRegister = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ram_writePulse !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_latch wp=%b busy=%b required 1/1", ram_writePulse, busy); end
        init_n = 1'b0;
        #1;
        checks++; if ({ram_writePulse, ram_we, done, busy, overrun, wrapped} !== 6'b0 || ptr !== '0 || ram_addr !== '0 || ram_din !== '0) begin
            errors++; $display("FAIL mid_reset wp=%b we=%b busy=%b ptr=%0d addr=%0d required all 0", ram_writePulse, ram_we, busy, ptr, ram_addr); end
        @(negedge clk);
        init_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL mid_no_write count=%0d exp=0", wr_addr_q.size()); end
        send(32'h8000_000A, DEC, 1, n);
        wait_idle();
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 10 || wr_cyc_q[0] != n + 3 || wr_din_q[0] !== pattern) begin
            errors++; $display("FAIL mid_recover count=%0d cyc=%0d required 1 write to 10 at %0d", wr_addr_q.size(), wr_cyc_q.size() ? wr_cyc_q[0] : -1, n + 3); end
        $display("reset_mid: aborted, recovery write@%0d", wr_cyc_q.size() ? wr_cyc_q[0] : -1);
    endtask

    initial begin
        test_reset();
        test_direct();
        test_ptr_mode();
        test_random_mix();
        test_overrun();
        test_clear_busy();
        test_clear_go();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_ram_loader756.md
GF_RAM_LOADER756 -- requirements
Module: gf_ram_loader756

Interface
REQ-001 Parameters SHALL be: WIDTH default 756, wide-word width; DEPTH_LOG2 default 10, pattern-RAM address width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock
- init_n  in  1  reset, asynchronous, active-low
- address  in  16  VME internal address
- DECODE_ADDRESS  in  16  command-register decode value
- writeRegister  in  1  VME write strobe, level, may last many cycles
- data  in  32  VME write data (command word)
- ram_writePulse  out  1  enables the 756-bit register's tristate drive onto ram_data_bus
- ram_data_bus  in  WIDTH  wide word from the 756-bit register
- ram_we  out  1  pattern-RAM write enable
- ram_addr  out  DEPTH_LOG2  pattern-RAM address
- ram_din  out  WIDTH  pattern-RAM write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- ptr  out  DEPTH_LOG2  auto-increment pointer
- overrun  out  1  sticky: command dropped while busy
- wrapped  out  1  sticky: pointer wrapped past DEPTH-1

Function
REQ-003 cmd_sel SHALL be (address == DECODE_ADDRESS) && writeRegister; one cmd_pulse per strobe: cmd_pulse is high in the first cycle cmd_sel is registered high, then vetoed until writeRegister falls.
REQ-004 Command word fields SHALL be: data[31] go; data[30] use ptr (1) or data[DEPTH_LOG2-1:0] (0) as target; data[29] clear (ptr:=0, overrun:=0, wrapped:=0).
REQ-005 Command data SHALL be sampled in the cmd_pulse cycle.
REQ-006 FSM states SHALL be IDLE, DRIVE, LATCH, WRITE.
REQ-007 IDLE -> DRIVE on cmd_pulse with go=1; the target address is latched in the same cycle.
REQ-008 DRIVE -> LATCH unconditionally; ram_writePulse=1 in DRIVE and LATCH only.
REQ-009 In LATCH the holding register SHALL capture ram_data_bus; -> WRITE.
REQ-010 In WRITE: ram_we=1 for exactly one cycle, ram_addr = latched target, ram_din = holding register; done=1 in the same cycle; -> IDLE.
REQ-011 Latency SHALL be fixed: cmd_pulse in cycle N gives DRIVE in N+1, LATCH in N+2, WRITE/done in N+3.
REQ-012 busy SHALL be 1 in DRIVE, LATCH and WRITE, and 0 in IDLE.
REQ-013 When data[30]=1, ptr SHALL increment in the WRITE cycle; DEPTH-1 wraps to 0 and sets wrapped.
REQ-014 A cmd_pulse with go=1 while busy SHALL be dropped and SHALL set overrun; the FSM is unaffected.
REQ-015 A clear while busy SHALL be honoured, but ptr SHALL NOT increment for the in-flight transfer.
REQ-016 go=1 with clear=1 SHALL clear first: a ptr-mode transfer targets address 0.
REQ-017 A clear coinciding with a wrap SHALL result in wrapped=0 and ptr=0.
REQ-018 A cmd_pulse with go=0 and clear=0 SHALL have no effect.
REQ-019 ram_addr and ram_din SHALL hold their last values outside WRITE; ram_we=0 outside WRITE.

Reset
REQ-020 init_n low SHALL asynchronously force: state=IDLE, ram_writePulse=0, ram_we=0, done=0, busy=0, ptr=0, overrun=0, wrapped=0, ram_addr=0, ram_din=0, holding register=0, veto=0.
REQ-021 Reset asserted mid-transfer SHALL abort with no RAM write; after release the block SHALL accept a new command within one cycle.
REQ-022 Reset SHALL be released synchronously to clk by the top level; the block SHALL NOT synchronise it internally.

Structure
REQ-023 Shared package gf_loader_pkg SHALL hold: FSM state enum, WIDTH=756, DEPTH_LOG2=10, command bit positions (GO=31, USE_PTR=30, CLR=29).
REQ-024 The strobe edge/veto logic SHALL be one sub-module, gf_write_edge_detect, reusable by other VME registers.
REQ-025 No other hierarchy SHALL exist; the RAM is external.

Verification
REQ-026 Direct write: bus=pattern A, data=0x8000_0005 -> ram_writePulse high cycles N+1..N+2, ram_we at N+3 with addr 5 and din A, done pulse, ptr=0.
REQ-027 Pointer mode: three writes of 0xC000_0000 with distinct patterns -> RAM addresses 0,1,2 receive them in order; ptr=3.
REQ-028 Wrap: clear, then 1024 ptr-mode writes -> last write at addr 1023, ptr=0, wrapped=1; clear -> wrapped=0.
REQ-029 Overrun: second go command issued at N+1 -> exactly one ram_we, overrun=1; a long writeRegister strobe (20 cycles) -> exactly one transfer.
REQ-030 Reset in LATCH -> no ram_we, all outputs at reset values; next command completes normally with 3-cycle latency.
REQ-031 Clear+go (0xE000_0000) with ptr=7 -> write at addr 0, ptr=1.
